// File: rtl/vx_issue_scb_pkg.sv
// Shared sizing helpers and request/writeback types for the counting issue scoreboard.
// Optional per-channel stall counters are enabled with the ISSUE_SCB_PERF_EN macro.
package vx_issue_scb_pkg;

    localparam int PERF_CTR_W = 44;

    // Request structs carry indices at a fixed maximum width; slices keep only the low bits they need.
    localparam int SCB_ID_W = 8;

    function automatic int calcNrBits(input int numRegs);
        return (numRegs > 1) ? $clog2(numRegs) : 1;
    endfunction

    function automatic int calcWidBits(input int warps);
        return (warps > 1) ? $clog2(warps) : 1;
    endfunction

    typedef struct packed {
        logic [SCB_ID_W-1:0] wid;
        logic                wb;
        logic [SCB_ID_W-1:0] rd;
        logic [SCB_ID_W-1:0] rs1;
        logic [SCB_ID_W-1:0] rs2;
        logic [SCB_ID_W-1:0] rs3;
    } scb_req_t;

    typedef struct packed {
        logic [SCB_ID_W-1:0] wid;
        logic [SCB_ID_W-1:0] rd;
        logic                eop;
    } scb_wb_t;

endpackage

// File: rtl/vx_issue_scb_slice.sv
// One issue channel: per-warp/per-register in-flight counters, hazard check and output register.
// Defining ISSUE_SCB_PERF_EN adds a stall counter output o_perfStalls.
module vx_issue_scb_slice
    import vx_issue_scb_pkg::*;
#(
    parameter int WARPS_PER_CH = 4,
    parameter int NUM_REGS     = 64,
    parameter int CNT_WIDTH    = 2,
    parameter int DATAW        = 64,
    localparam int WID_BITS    = calcWidBits(WARPS_PER_CH),
    localparam int NR_BITS     = calcNrBits(NUM_REGS)
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_inValid,
    output logic                o_inReady,
    input  scb_req_t            i_req,
    input  logic [DATAW-1:0]    i_data,
    output logic                o_outValid,
    input  logic                i_outReady,
    output logic [WID_BITS-1:0] o_outWid,
    output logic [DATAW-1:0]    o_outData,
    input  logic                i_wbValid,
    input  scb_wb_t             i_wb
`ifdef ISSUE_SCB_PERF_EN
    ,
    output logic [PERF_CTR_W-1:0] o_perfStalls
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_cnt [WARPS_PER_CH][NUM_REGS];
    logic                 r_outValid;
    logic [WID_BITS-1:0]  r_outWid;
    logic [DATAW-1:0]     r_outData;
    logic [4:0]           r_quietCnt;

    logic [WID_BITS-1:0]  w_wid;
    logic [WID_BITS-1:0]  w_wbWid;
    logic [NR_BITS-1:0]   w_rd;
    logic [NR_BITS-1:0]   w_rs1;
    logic [NR_BITS-1:0]   w_rs2;
    logic [NR_BITS-1:0]   w_rs3;
    logic [NR_BITS-1:0]   w_wbRd;
    logic                 w_unusedIds;
    logic                 w_rawHaz;
    logic                 w_satHaz;
    logic                 w_hazard;
    logic                 w_fire;
    logic                 w_incEn;
    logic                 w_decEn;
    logic                 w_sameCell;
    logic                 w_decAtZero;

    assign w_wid   = i_req.wid[WID_BITS-1:0];
    assign w_rd    = i_req.rd[NR_BITS-1:0];
    assign w_rs1   = i_req.rs1[NR_BITS-1:0];
    assign w_rs2   = i_req.rs2[NR_BITS-1:0];
    assign w_rs3   = i_req.rs3[NR_BITS-1:0];
    assign w_wbWid = i_wb.wid[WID_BITS-1:0];
    assign w_wbRd  = i_wb.rd[NR_BITS-1:0];
    assign w_unusedIds = ^{i_req, i_wb};

    // Register 0 never counts, so it can never raise a hazard.
    assign w_rawHaz = ((w_rs1 != '0) && (r_cnt[w_wid][w_rs1] != '0)) ||
                      ((w_rs2 != '0) && (r_cnt[w_wid][w_rs2] != '0)) ||
                      ((w_rs3 != '0) && (r_cnt[w_wid][w_rs3] != '0));
    assign w_satHaz = i_req.wb && (w_rd != '0) && (r_cnt[w_wid][w_rd] == CNT_MAX);
    assign w_hazard = w_rawHaz || w_satHaz;

    assign o_inReady = ~w_hazard & (~r_outValid | i_outReady);
    assign w_fire    = i_inValid & o_inReady;

    assign w_incEn     = w_fire & i_req.wb & (w_rd != '0);
    assign w_decEn     = i_wbValid & i_wb.eop & (w_wbRd != '0);
    assign w_sameCell  = w_incEn && w_decEn && (w_wid == w_wbWid) && (w_rd == w_wbRd);
    assign w_decAtZero = w_decEn && !w_sameCell && (r_cnt[w_wbWid][w_wbRd] == '0);

    // An increment and a decrement on the same cell cancel; a decrement of an idle cell is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < WARPS_PER_CH; w++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    r_cnt[w][r] <= '0;
                end
            end
        end else begin
            if (w_incEn && !w_sameCell) begin
                r_cnt[w_wid][w_rd] <= r_cnt[w_wid][w_rd] + CNT_ONE;
            end
            if (w_decEn && !w_sameCell && (r_cnt[w_wbWid][w_wbRd] != '0)) begin
                r_cnt[w_wbWid][w_wbRd] <= r_cnt[w_wbWid][w_wbRd] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_outWid   <= '0;
            r_outData  <= '0;
        end else if (w_fire) begin
            r_outValid <= 1'b1;
            r_outWid   <= w_wid;
            r_outData  <= i_data;
        end else if (i_outReady) begin
            r_outValid <= 1'b0;
        end
    end

    assign o_outValid = r_outValid;
    assign o_outWid   = r_outWid;
    assign o_outData  = r_outData;

    // Writebacks still in flight across a reset land on cleared counters; tolerate them briefly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_quietCnt <= 5'd16;
        end else if (r_quietCnt != 5'd0) begin
            r_quietCnt <= r_quietCnt - 5'd1;
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(w_decAtZero && (r_quietCnt == 5'd0)));

`ifdef ISSUE_SCB_PERF_EN
    logic [PERF_CTR_W-1:0] r_perfStalls;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perfStalls <= '0;
        end else if (i_inValid && w_hazard) begin
            r_perfStalls <= r_perfStalls + PERF_CTR_W'(1);
        end
    end

    assign o_perfStalls = r_perfStalls;
`endif

endmodule

// File: rtl/vx_issue_scoreboard_cnt.sv
// Counting issue scoreboard: ISSUE_WIDTH independent channel slices plus bus slicing.
// Defining ISSUE_SCB_PERF_EN adds the perf_stalls output.
module vx_issue_scoreboard_cnt
    import vx_issue_scb_pkg::*;
#(
    parameter int ISSUE_WIDTH  = 1,
    parameter int WARPS_PER_CH = 4,
    parameter int NUM_REGS     = 64,
    parameter int CNT_WIDTH    = 2,
    parameter int DATAW        = 64,
    localparam int WID_BITS    = calcWidBits(WARPS_PER_CH),
    localparam int NR_BITS     = calcNrBits(NUM_REGS)
)(
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ISSUE_WIDTH-1:0]          in_valid,
    output logic [ISSUE_WIDTH-1:0]          in_ready,
    input  logic [ISSUE_WIDTH*WID_BITS-1:0] in_wid,
    input  logic [ISSUE_WIDTH-1:0]          in_wb,
    input  logic [ISSUE_WIDTH*NR_BITS-1:0]  in_rd,
    input  logic [ISSUE_WIDTH*NR_BITS-1:0]  in_rs1,
    input  logic [ISSUE_WIDTH*NR_BITS-1:0]  in_rs2,
    input  logic [ISSUE_WIDTH*NR_BITS-1:0]  in_rs3,
    input  logic [ISSUE_WIDTH*DATAW-1:0]    in_data,
    output logic [ISSUE_WIDTH-1:0]          out_valid,
    input  logic [ISSUE_WIDTH-1:0]          out_ready,
    output logic [ISSUE_WIDTH*WID_BITS-1:0] out_wid,
    output logic [ISSUE_WIDTH*DATAW-1:0]    out_data,
    input  logic [ISSUE_WIDTH-1:0]          wb_valid,
    input  logic [ISSUE_WIDTH*WID_BITS-1:0] wb_wid,
    input  logic [ISSUE_WIDTH*NR_BITS-1:0]  wb_rd,
    input  logic [ISSUE_WIDTH-1:0]          wb_eop
`ifdef ISSUE_SCB_PERF_EN
    ,
    output logic [ISSUE_WIDTH*PERF_CTR_W-1:0] perf_stalls
`endif
);

    for (genvar c = 0; c < ISSUE_WIDTH; c++) begin : g_ch
        scb_req_t w_req;
        scb_wb_t  w_wbInfo;

        assign w_req.wid = SCB_ID_W'(in_wid[c*WID_BITS +: WID_BITS]);
        assign w_req.wb  = in_wb[c];
        assign w_req.rd  = SCB_ID_W'(in_rd[c*NR_BITS +: NR_BITS]);
        assign w_req.rs1 = SCB_ID_W'(in_rs1[c*NR_BITS +: NR_BITS]);
        assign w_req.rs2 = SCB_ID_W'(in_rs2[c*NR_BITS +: NR_BITS]);
        assign w_req.rs3 = SCB_ID_W'(in_rs3[c*NR_BITS +: NR_BITS]);

        assign w_wbInfo.wid = SCB_ID_W'(wb_wid[c*WID_BITS +: WID_BITS]);
        assign w_wbInfo.rd  = SCB_ID_W'(wb_rd[c*NR_BITS +: NR_BITS]);
        assign w_wbInfo.eop = wb_eop[c];

        vx_issue_scb_slice #(
            .WARPS_PER_CH (WARPS_PER_CH),
            .NUM_REGS     (NUM_REGS),
            .CNT_WIDTH    (CNT_WIDTH),
            .DATAW        (DATAW)
        ) u_slice (
            .clk          (clk),
            .reset        (reset),
            .i_inValid    (in_valid[c]),
            .o_inReady    (in_ready[c]),
            .i_req        (w_req),
            .i_data       (in_data[c*DATAW +: DATAW]),
            .o_outValid   (out_valid[c]),
            .i_outReady   (out_ready[c]),
            .o_outWid     (out_wid[c*WID_BITS +: WID_BITS]),
            .o_outData    (out_data[c*DATAW +: DATAW]),
            .i_wbValid    (wb_valid[c]),
            .i_wb         (w_wbInfo)
`ifdef ISSUE_SCB_PERF_EN
            ,
            .o_perfStalls (perf_stalls[c*PERF_CTR_W +: PERF_CTR_W])
`endif
        );
    end

endmodule

// File: tb/tb_vx_issue_scoreboard_cnt.sv
// Self-checking bench for vx_issue_scoreboard_cnt (two channels): vector table, corner sequences, random traffic.
// Also checks perf_stalls when ISSUE_SCB_PERF_EN is defined.
module tb_vx_issue_scoreboard_cnt;

    localparam int NCH      = 2;
    localparam int WARPS    = 4;
    localparam int NREGS    = 64;
    localparam int WID_BITS = 2;
    localparam int NR_BITS  = 6;
    localparam int DATAW    = 64;
    localparam int CNT_MAX  = 3;
    localparam int PW       = 44;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NCH-1:0]           in_valid, in_ready, in_wb, out_valid, out_ready, wb_valid, wb_eop;
    logic [NCH*WID_BITS-1:0]  in_wid, out_wid, wb_wid;
    logic [NCH*NR_BITS-1:0]   in_rd, in_rs1, in_rs2, in_rs3, wb_rd;
    logic [NCH*DATAW-1:0]     in_data, out_data;
`ifdef ISSUE_SCB_PERF_EN
    logic [NCH*PW-1:0]        perf_stalls;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding-write count per register, plus a one-entry output stage.
    int             mCnt [NCH][WARPS][NREGS];
    bit             mOutV [NCH];
    int             mOutWid [NCH];
    logic [63:0]    mOutData [NCH];
    logic [PW-1:0]  mPerf [NCH];

    typedef struct {
        bit inValid; int wid; bit wb; int rd; int rs1;
        bit wbValid; int wbWid; int wbRd; bit wbEop;
        bit expReady; bit expOutValid;
    } vec_t;
    vec_t vecs[13];

    vx_issue_scoreboard_cnt #(
        .ISSUE_WIDTH(NCH), .WARPS_PER_CH(WARPS), .NUM_REGS(NREGS), .CNT_WIDTH(2), .DATAW(DATAW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_wb(in_wb),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_data(out_data),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop)
`ifdef ISSUE_SCB_PERF_EN
        , .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    function automatic int getWid(input logic [NCH*WID_BITS-1:0] bus, input int ch);
        return int'(bus[ch*WID_BITS +: WID_BITS]);
    endfunction

    function automatic int getReg(input logic [NCH*NR_BITS-1:0] bus, input int ch);
        return int'(bus[ch*NR_BITS +: NR_BITS]);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic bit mHazard(input int ch);
        int w;
        int srcs[3];
        bit h;
        w = getWid(in_wid, ch);
        srcs[0] = getReg(in_rs1, ch);
        srcs[1] = getReg(in_rs2, ch);
        srcs[2] = getReg(in_rs3, ch);
        h = 1'b0;
        foreach (srcs[k]) if (srcs[k] != 0 && mCnt[ch][w][srcs[k]] > 0) h = 1'b1;
        if (in_wb[ch] && getReg(in_rd, ch) != 0 && mCnt[ch][w][getReg(in_rd, ch)] >= CNT_MAX) h = 1'b1;
        return h;
    endfunction

    function automatic bit mReady(input int ch);
        return !mHazard(ch) && (!mOutV[ch] || out_ready[ch]);
    endfunction

    task automatic checkVal(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s ch%0d at %0t: got 0x%0h, expected 0x%0h", name, ch, $time, act, exp);
        end
    endtask

    task automatic setCh(input int ch, input bit v, input int wid, input bit wb, input int rd,
                         input int r1, input int r2, input int r3, input logic [63:0] d);
        in_valid[ch] = v;
        in_wid[ch*WID_BITS +: WID_BITS] = WID_BITS'(wid);
        in_wb[ch] = wb;
        in_rd[ch*NR_BITS +: NR_BITS]  = NR_BITS'(rd);
        in_rs1[ch*NR_BITS +: NR_BITS] = NR_BITS'(r1);
        in_rs2[ch*NR_BITS +: NR_BITS] = NR_BITS'(r2);
        in_rs3[ch*NR_BITS +: NR_BITS] = NR_BITS'(r3);
        in_data[ch*DATAW +: DATAW] = d;
    endtask

    task automatic setWb(input int ch, input bit v, input int wid, input int rd, input bit eop);
        wb_valid[ch] = v;
        wb_wid[ch*WID_BITS +: WID_BITS] = WID_BITS'(wid);
        wb_rd[ch*NR_BITS +: NR_BITS] = NR_BITS'(rd);
        wb_eop[ch] = eop;
    endtask

    task automatic idleAll();
        for (int ch = 0; ch < NCH; ch++) begin
            setCh(ch, 1'b0, 0, 1'b0, 0, 0, 0, 0, 64'd0);
            setWb(ch, 1'b0, 0, 0, 1'b0);
        end
        out_ready = '1;
    endtask

    // Compares every DUT output against the model, mid-cycle.
    task automatic checkOutput();
        #2;
        for (int ch = 0; ch < NCH; ch++) begin
            checkVal("in_ready", ch, 64'(in_ready[ch]), 64'(mReady(ch)));
            checkVal("out_valid", ch, 64'(out_valid[ch]), 64'(mOutV[ch]));
            checkVal("out_wid", ch, 64'(out_wid[ch*WID_BITS +: WID_BITS]), 64'(mOutWid[ch]));
            checkVal("out_data", ch, out_data[ch*DATAW +: DATAW], mOutData[ch]);
`ifdef ISSUE_SCB_PERF_EN
            checkVal("perf_stalls", ch, 64'(perf_stalls[ch*PW +: PW]), 64'(mPerf[ch]));
`endif
        end
    endtask

    // Advances the model by one cycle from the current inputs, then clocks the DUT.
    task automatic applyStimulus();
        bit fire [NCH];
        bit hz [NCH];
        for (int ch = 0; ch < NCH; ch++) begin
            hz[ch] = mHazard(ch);
            fire[ch] = in_valid[ch] && mReady(ch);
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (reset) begin
                foreach (mCnt[ch][w, r]) mCnt[ch][w][r] = 0;
                mOutV[ch] = 1'b0;
                mOutWid[ch] = 0;
                mOutData[ch] = 64'd0;
                mPerf[ch] = '0;
            end else begin
                if (fire[ch] && in_wb[ch] && getReg(in_rd, ch) != 0)
                    mCnt[ch][getWid(in_wid, ch)][getReg(in_rd, ch)]++;
                if (wb_valid[ch] && wb_eop[ch] && getReg(wb_rd, ch) != 0 &&
                    mCnt[ch][getWid(wb_wid, ch)][getReg(wb_rd, ch)] > 0)
                    mCnt[ch][getWid(wb_wid, ch)][getReg(wb_rd, ch)]--;
                if (fire[ch]) begin
                    mOutV[ch] = 1'b1;
                    mOutWid[ch] = getWid(in_wid, ch);
                    mOutData[ch] = in_data[ch*DATAW +: DATAW];
                end else if (out_ready[ch]) begin
                    mOutV[ch] = 1'b0;
                end
                if (in_valid[ch] && hz[ch]) mPerf[ch] = mPerf[ch] + PW'(1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] d1;
        logic [63:0] prevData;
`ifdef ISSUE_SCB_PERF_EN
        logic [PW-1:0] perfHold;
`endif
        vecs[0]  = '{1, 0, 1, 5, 0, 0, 0, 0, 0, 1, 0};
        vecs[1]  = '{1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 1};
        vecs[2]  = '{1, 0, 0, 0, 5, 1, 0, 5, 1, 0, 0};
        vecs[3]  = '{1, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vecs[5]  = '{1, 1, 1, 7, 0, 0, 0, 0, 0, 1, 0};
        vecs[6]  = '{1, 1, 1, 7, 0, 0, 0, 0, 0, 1, 1};
        vecs[7]  = '{1, 1, 1, 7, 0, 0, 0, 0, 0, 1, 1};
        vecs[8]  = '{1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 1};
        vecs[9]  = '{1, 1, 1, 7, 0, 1, 1, 7, 0, 0, 0};
        vecs[10] = '{1, 1, 1, 7, 0, 1, 1, 7, 1, 0, 0};
        vecs[11] = '{1, 1, 1, 7, 0, 0, 0, 0, 0, 1, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

        reset = 1'b1;
        idleAll();
        #1;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput();
        for (int ch = 0; ch < NCH; ch++) begin
            checkVal("reset_out_valid", ch, 64'(out_valid[ch]), 64'd0);
            checkVal("reset_out_data", ch, out_data[ch*DATAW +: DATAW], 64'd0);
            checkVal("reset_in_ready", ch, 64'(in_ready[ch]), 64'd1);
        end
        applyStimulus();

        $display("[TB] vector table: RAW release and WAW saturation");
        for (int i = 0; i < 13; i++) begin
            idleAll();
            setCh(0, vecs[i].inValid, vecs[i].wid, vecs[i].wb, vecs[i].rd, vecs[i].rs1, 0, 0, rnd64());
            setWb(0, vecs[i].wbValid, vecs[i].wbWid, vecs[i].wbRd, vecs[i].wbEop);
            checkOutput();
            checkVal($sformatf("vec%0d_in_ready", i), 0, 64'(in_ready[0]), 64'(vecs[i].expReady));
            checkVal($sformatf("vec%0d_out_valid", i), 0, 64'(out_valid[0]), 64'(vecs[i].expOutValid));
            applyStimulus();
        end
        for (int i = 0; i < 3; i++) begin
            idleAll();
            setWb(0, 1'b1, 1, 7, 1'b1);
            checkOutput();
            applyStimulus();
        end

        $display("[TB] same-cycle increment and decrement");
        idleAll();
        setCh(0, 1'b1, 2, 1'b1, 3, 0, 0, 0, rnd64());
        checkOutput();
        applyStimulus();
        setWb(0, 1'b1, 2, 3, 1'b1);
        checkOutput();
        checkVal("samecell_write_ready", 0, 64'(in_ready[0]), 64'd1);
        applyStimulus();
        idleAll();
        setCh(0, 1'b1, 2, 1'b0, 0, 0, 3, 0, rnd64());
        checkOutput();
        checkVal("samecell_reader_blocked", 0, 64'(in_ready[0]), 64'd0);
        applyStimulus();
        setWb(0, 1'b1, 2, 3, 1'b1);
        checkOutput();
        checkVal("samecell_reader_wb_cycle", 0, 64'(in_ready[0]), 64'd0);
        applyStimulus();
        setWb(0, 1'b0, 0, 0, 1'b0);
        checkOutput();
        checkVal("samecell_reader_released", 0, 64'(in_ready[0]), 64'd1);
        applyStimulus();

        $display("[TB] register 0 is never pending");
        for (int i = 0; i < 10; i++) begin
            idleAll();
            setCh(0, 1'b1, 3, 1'b1, 0, 0, 0, 0, rnd64());
            setWb(0, 1'b1, 3, 0, 1'b1);
            checkOutput();
            checkVal($sformatf("r0_ready_%0d", i), 0, 64'(in_ready[0]), 64'd1);
            applyStimulus();
        end

        $display("[TB] output backpressure");
        idleAll();
        applyStimulus();
        d1 = rnd64();
        out_ready = '0;
        setCh(0, 1'b1, 1, 1'b0, 0, 0, 0, 0, d1);
        checkOutput();
        checkVal("bp_first_ready", 0, 64'(in_ready[0]), 64'd1);
        applyStimulus();
`ifdef ISSUE_SCB_PERF_EN
        perfHold = perf_stalls[PW-1:0];
`endif
        setCh(0, 1'b1, 2, 1'b0, 0, 0, 0, 0, rnd64());
        for (int i = 0; i < 4; i++) begin
            checkOutput();
            checkVal("bp_in_ready", 0, 64'(in_ready[0]), 64'd0);
            checkVal("bp_out_valid", 0, 64'(out_valid[0]), 64'd1);
            checkVal("bp_out_data_stable", 0, out_data[DATAW-1:0], d1);
`ifdef ISSUE_SCB_PERF_EN
            checkVal("bp_perf_flat", 0, 64'(perf_stalls[PW-1:0]), 64'(perfHold));
`endif
            applyStimulus();
        end
        out_ready = '1;
        prevData = d1;
        for (int i = 0; i < 5; i++) begin
            checkOutput();
            checkVal("stream_ready", 0, 64'(in_ready[0]), 64'd1);
            checkVal("stream_out_data", 0, out_data[DATAW-1:0], prevData);
            prevData = in_data[DATAW-1:0];
            applyStimulus();
            setCh(0, 1'b1, i % WARPS, 1'b0, 0, 0, 0, 0, rnd64());
        end

        $display("[TB] channel independence and mid-stream reset");
        idleAll();
        setCh(0, 1'b1, 0, 1'b1, 9, 0, 0, 0, rnd64());
        checkOutput();
        applyStimulus();
        for (int i = 1; i <= 8; i++) begin
            idleAll();
            setCh(0, 1'b1, 0, 1'b0, 0, 9, 0, 0, rnd64());
            setCh(1, 1'b1, i % WARPS, 1'b1, 10 + i, 0, 0, 0, rnd64());
            reset = (i == 5);
            if (i == 6) begin
                setWb(0, 1'b1, 0, 9, 1'b1);
                setWb(1, 1'b1, 1, 11, 1'b1);
            end
            checkOutput();
            if (i <= 5) checkVal("indep_ch0_blocked", 0, 64'(in_ready[0]), 64'd0);
            if (i != 5) checkVal("indep_ch1_ready", 1, 64'(in_ready[1]), 64'd1);
            if (i >= 2 && i != 6) checkVal("indep_ch1_out_valid", 1, 64'(out_valid[1]), 64'd1);
            if (i == 6) begin
                checkVal("rst_out_valid", 0, 64'(out_valid[0]), 64'd0);
                checkVal("rst_out_valid", 1, 64'(out_valid[1]), 64'd0);
                checkVal("rst_counter_cleared", 0, 64'(in_ready[0]), 64'd1);
            end
            applyStimulus();
        end
        reset = 1'b0;

        $display("[TB] random traffic");
        for (int n = 0; n < 800; n++) begin
            idleAll();
            for (int ch = 0; ch < NCH; ch++) begin
                int w;
                int r;
                setCh(ch, $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                      $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2) == 0 ? $urandom_range(0, 7) : 0,
                      $urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : 0, rnd64());
                w = $urandom_range(0, 3);
                r = $urandom_range(1, 7);
                if (mCnt[ch][w][r] > 0) setWb(ch, 1'b1, w, r, $urandom_range(0, 3) != 0);
                else if ($urandom_range(0, 7) == 0) setWb(ch, 1'b1, w, 0, 1'b1);
                else setWb(ch, $urandom_range(0, 1), w, r, 1'b0);
                out_ready[ch] = $urandom_range(0, 3) != 0;
            end
            checkOutput();
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
